// File: rtl/aes_ctr_engine.sv
// AES counter-mode controller: builds {nonce, ctr} blocks, drives a start/done
// cipher core, and XORs each keystream block with the matching stream block.
module aes_ctr_engine #(
  parameter int CTR_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [255:0]         key_i,
  input  logic [127:0]         iv_i,
  input  logic [LEN_WIDTH-1:0] num_blocks_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wrap_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [127:0]         in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [127:0]         out_data_o,
  output logic                 core_start_o,
  output logic [127:0]         core_block_o,
  output logic [255:0]         core_key_o,
  input  logic                 core_done_i,
  input  logic [127:0]         core_result_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT,
    S_MIX,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                 state;
  state_t                 state_next;
  logic [255:0]           key_q;
  logic [127:0]           block_q;
  logic [127:0]           keystream_q;
  logic [127:0]           out_data_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic                   wrap_q;
  logic                   last_block;
  logic                   ctr_all_ones;

  assign last_block   = (remaining_q == LEN_ONE);
  assign ctr_all_ones = &block_q[CTR_WIDTH-1:0];

  assign out_data_o   = out_data_q;
  assign core_block_o = block_q;
  assign core_key_o   = key_q;
  assign wrap_o       = wrap_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy_o       = (state != S_IDLE);
    core_start_o = 1'b0;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    done_o       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = (num_blocks_i == '0) ? S_DONE : S_GEN;
        end
      end
      S_GEN: begin
        core_start_o = 1'b1;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          state_next = S_MIX;
        end
      end
      S_MIX: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_next = last_block ? S_DONE : S_GEN;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Only the low CTR_WIDTH bits advance, so the nonce never sees a carry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q       <= '0;
      block_q     <= '0;
      keystream_q <= '0;
      out_data_q  <= '0;
      remaining_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            key_q       <= key_i;
            block_q     <= iv_i;
            remaining_q <= num_blocks_i;
            wrap_q      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (core_done_i) begin
            keystream_q <= core_result_i;
          end
        end
        S_MIX: begin
          if (in_valid_i) begin
            out_data_q <= in_data_i ^ keystream_q;
          end
        end
        S_OUT: begin
          if (out_ready_i && !last_block) begin
            block_q[CTR_WIDTH-1:0] <= block_q[CTR_WIDTH-1:0] + CTR_ONE;
            remaining_q            <= remaining_q - LEN_ONE;
            if (ctr_all_ones) begin
              wrap_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_engine.sv
// Scoreboard bench for aes_ctr_engine: a 14-cycle core model, directed messages,
// and a negedge monitor that pops expected output blocks on each handshake.
module tb_aes_ctr_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic [255:0] key_i = '0;
  logic [127:0] iv_i = '0;
  logic [15:0]  num_blocks_i = '0;
  logic         busy_o, done_o, wrap_o;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] in_data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [127:0] out_data_o;
  logic         core_start_o;
  logic [127:0] core_block_o;
  logic [255:0] core_key_o;
  logic         core_done_i = 1'b0;
  logic [127:0] core_result_i = '0;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int ready_cnt = 0;
  int core_cd = 0;
  logic [127:0] core_res = '0;
  logic [127:0] exp_q[$];
  logic [127:0] vec_in[4];
  logic [127:0] vec_exp[4];
  logic         vec_wrap[4];

  always #5 clk = ~clk;

  aes_ctr_engine #(.CTR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i), .iv_i(iv_i),
    .num_blocks_i(num_blocks_i), .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .core_start_o(core_start_o), .core_block_o(core_block_o), .core_key_o(core_key_o),
    .core_done_i(core_done_i), .core_result_i(core_result_i)
  );

  // Core model ignores rst on purpose so a result can arrive after a reset.
  always @(posedge clk) begin
    core_done_i <= 1'b0;
    if (core_cd > 0) begin
      core_cd = core_cd - 1;
      if (core_cd == 0) begin
        core_done_i   <= 1'b1;
        core_result_i <= core_res;
      end
    end
    if (core_start_o) begin
      core_res = core_block_o ^ core_key_o[255:128];
      core_cd  = 14;
    end
  end

  always @(negedge clk) begin
    logic [127:0] e;
    if (core_start_o) start_cnt++;
    if (in_ready_o) ready_cnt++;
    if (out_valid_o && out_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL out_block: got %h with no block expected", out_data_o);
      end else begin
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          bad++;
          $display("[TB] FAIL out_block: got %h expected %h", out_data_o, e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    for (int i = 0; i < 200; i++) begin
      if (in_ready_o) break;
      tick();
    end
    checkBit("in_ready_seen", in_ready_o, 1'b1);
  endtask

  task automatic applyStimulus(input logic [255:0] key, input logic [127:0] iv,
                               input logic [15:0] n, input int in_stall, input int out_stall);
    start_cnt = 0;
    ready_cnt = 0;
    tick();
    start_i = 1'b1; key_i = key; iv_i = iv; num_blocks_i = n;
    tick();
    start_i = 1'b0;
    if (n == 16'd0) begin
      checkBit("zero_done", done_o, 1'b1);
      tick();
      checkBit("zero_busy_low", busy_o, 1'b0);
      checkOutput("zero_core_starts", 256'(start_cnt), 256'(0));
      checkOutput("zero_in_ready", 256'(ready_cnt), 256'(0));
      return;
    end
    checkBit("gen_pulse", core_start_o, 1'b1);
    for (int b = 0; b < int'(n); b++) begin
      waitReady();
      if (!in_ready_o) return;
      if (b == in_stall) begin
        repeat (4) tick();
        checkBit("mix_hold", in_ready_o, 1'b1);
      end
      in_data_i  = vec_in[b];
      in_valid_i = 1'b1;
      exp_q.push_back(vec_exp[b]);
      if (b == out_stall) out_ready_i = 1'b0;
      tick();
      in_valid_i = 1'b0;
      checkBit("out_valid", out_valid_o, 1'b1);
      if (b == out_stall) begin
        repeat (5) begin
          checkOutput("stall_hold", 256'(out_data_o), 256'(vec_exp[b]));
          tick();
        end
        out_ready_i = 1'b1;
      end
      tick();
      checkBit("wrap_flag", wrap_o, vec_wrap[b]);
    end
    checkBit("done_pulse", done_o, 1'b1);
    tick();
    checkBit("done_clear", done_o, 1'b0);
    checkBit("busy_low", busy_o, 1'b0);
    checkOutput("core_starts", 256'(start_cnt), 256'(n));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    checkBit("rst_busy", busy_o, 1'b0);
    checkBit("rst_done", done_o, 1'b0);
    checkBit("rst_out_valid", out_valid_o, 1'b0);
    checkOutput("rst_out_data", 256'(out_data_o), 256'(0));
    rst = 1'b1;
    tick();

    // Basic message: counters 0,1,2 with zero key and zero data.
    vec_in  = '{default: '0};
    vec_exp = '{128'h0, 128'h1, 128'h2, 128'h0};
    vec_wrap = '{1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(256'h0, 128'h0, 16'd3, -1, -1);

    // Nonce kept, key high half mixed in, counter wraps after block 2.
    vec_exp = '{128'hF0000000_00000000_00000000_FFFFFFFF,
                128'hF0000000_00000000_00000000_FFFFFFFE,
                128'hF0000000_00000000_00000000_00000001, 128'h0};
    vec_wrap = '{1'b0, 1'b1, 1'b1, 1'b0};
    applyStimulus({128'h1, 128'h0}, 128'hF0000000_00000000_00000000_FFFFFFFE, 16'd3, -1, -1);
    checkBit("wrap_sticky", wrap_o, 1'b1);

    // Backpressure on both handshakes.
    vec_exp = '{128'h0, 128'h1, 128'h2, 128'h0};
    vec_wrap = '{1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(256'h0, 128'h0, 16'd3, 1, 0);
    checkBit("wrap_cleared", wrap_o, 1'b0);

    applyStimulus(256'h0, 128'h0, 16'd0, -1, -1);

    // Start while busy is ignored, then reset during MIX.
    tick();
    start_i = 1'b1; key_i = '0; iv_i = 128'h10; num_blocks_i = 16'd2;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    start_i = 1'b1; key_i = {128'hDEAD, 128'hBEEF}; iv_i = 128'h99; num_blocks_i = 16'd5;
    tick();
    start_i = 1'b0;
    checkOutput("ignored_start_block", 256'(core_block_o), 256'(128'h10));
    checkOutput("ignored_start_key", core_key_o, 256'h0);
    waitReady();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkBit("mid_rst_busy", busy_o, 1'b0);
    checkBit("mid_rst_done", done_o, 1'b0);
    checkBit("mid_rst_wrap", wrap_o, 1'b0);
    checkBit("mid_rst_core_start", core_start_o, 1'b0);
    checkBit("mid_rst_in_ready", in_ready_o, 1'b0);
    checkBit("mid_rst_out_valid", out_valid_o, 1'b0);
    checkOutput("mid_rst_out_data", 256'(out_data_o), 256'(0));
    checkOutput("mid_rst_block", 256'(core_block_o), 256'(0));
    checkOutput("mid_rst_key", core_key_o, 256'h0);

    // Reset during WAIT so the core result lands while idle.
    start_i = 1'b1; key_i = '0; iv_i = 128'h20; num_blocks_i = 16'd1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (25) tick();
    checkBit("late_done_busy", busy_o, 1'b0);
    checkBit("late_done_in_ready", in_ready_o, 1'b0);

    vec_in  = '{128'h1, 128'h00000000_00000000_00000001_00000000, 128'h0, 128'h0};
    vec_exp = '{128'h12345678_00000000_00000000_000000EE,
                128'h12345678_00000000_00000001_000000EE, 128'h0, 128'h0};
    vec_wrap = '{1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus({128'hFF, 128'h0}, 128'h12345678_00000000_00000000_00000010, 16'd2, -1, -1);

    repeat (2) tick();
    checkOutput("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
